mem_bus_ctrl: RTL and testbench

- Bus-cycle sequencer and arbiter directly upstream of the 64 KB test memory.
- Accepts read/write requests from the CPU port and read-only requests from the MARIA DMA port. DMA has priority.
- Generates the non-overlapping phi1/phi2 strobes from one clock, drives the memory address/data/read_e inputs, and captures the memory's data_out.
- Asserts cpu_halt while DMA owns or is claiming the bus.

---
 rtl/mem_bus_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Bus-cycle sequencer/arbiter for the test memory: DMA-priority grant in IDLE, then SETUP/PH1/GAP/PH2/DONE.
// Ack lands 2+2*PHASE_LEN edges after accept; requesters are held off (gnt low) until the FSM is back in IDLE.
module mem_bus_ctrl #(
  parameter int unsigned PHASE_LEN = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_halt,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        phi1,
  output logic        phi2,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_in,
  output logic        mem_read_e,
  input  logic [7:0]  mem_data_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PH1   = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] PH2   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [3:0] PH_LAST = 4'(PHASE_LEN - 1);

  logic [2:0] state;
  logic [3:0] ph_cnt;
  logic       owner_dma;

  // The CPU is locked out while halted so the 6502 sees a clean handover.
  assign dma_gnt = (state == IDLE) & dma_req;
  assign cpu_gnt = (state == IDLE) & cpu_req & ~dma_req & ~cpu_halt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      ph_cnt      <= 4'd0;
      owner_dma   <= 1'b0;
      phi1        <= 1'b0;
      phi2        <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_data_in <= 8'h00;
      mem_read_e  <= 1'b1;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata   <= 8'h00;
      dma_rdata   <= 8'h00;
      cpu_halt    <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
      cpu_halt <= dma_req | (owner_dma & (state != IDLE));
      case (state)
        IDLE: begin
          if (dma_gnt) begin
            owner_dma  <= 1'b1;
            mem_addr   <= dma_addr;
            mem_read_e <= 1'b1;
            state      <= SETUP;
          end else if (cpu_gnt) begin
            owner_dma   <= 1'b0;
            mem_addr    <= cpu_addr;
            mem_read_e  <= ~cpu_we;
            mem_data_in <= cpu_wdata;
            state       <= SETUP;
          end
        end
        SETUP: begin
          phi1   <= 1'b1;
          ph_cnt <= PH_LAST;
          state  <= PH1;
        end
        PH1: begin
          if (ph_cnt == 4'd0) begin
            phi1  <= 1'b0;
            state <= GAP;
          end else begin
            ph_cnt <= ph_cnt - 4'd1;
          end
        end
        GAP: begin
          phi2   <= 1'b1;
          ph_cnt <= PH_LAST;
          state  <= PH2;
        end
        PH2: begin
          if (ph_cnt == 4'd0) begin
            phi2  <= 1'b0;
            state <= DONE;
            // Memory latched its output on the phi2 rise, so it is settled by this edge.
            if (owner_dma) begin
              dma_ack <= 1'b1;
              if (mem_read_e) dma_rdata <= mem_data_out;
            end else begin
              cpu_ack <= 1'b1;
              if (mem_read_e) cpu_rdata <= mem_data_out;
            end
          end else begin
            ph_cnt <= ph_cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
  localparam int P3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_ack, cpu_halt;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_gnt, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic        phi1, phi2, mem_read_e;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_in, mem_data_out;

  logic        cpu_req_3, cpu_we_3, cpu_gnt_3, cpu_ack_3, cpu_halt_3;
  logic [15:0] cpu_addr_3;
  logic [7:0]  cpu_wdata_3, cpu_rdata_3;
  logic        dma_req_3, dma_gnt_3, dma_ack_3;
  logic [15:0] dma_addr_3;
  logic [7:0]  dma_rdata_3;
  logic        phi1_3, phi2_3, mem_read_e_3;
  logic [15:0] mem_addr_3;
  logic [7:0]  mem_data_in_3, mem_data_out_3;

  int total = 0;
  int bad = 0;

  mem_bus_ctrl dut (
    .clk(clk), .rst_b(rst_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .phi1(phi1), .phi2(phi2), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_read_e(mem_read_e), .mem_data_out(mem_data_out)
  );

  mem_bus_ctrl #(.PHASE_LEN(P3)) dut3 (
    .clk(clk), .rst_b(rst_b),
    .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3),
    .cpu_gnt(cpu_gnt_3), .cpu_ack(cpu_ack_3), .cpu_rdata(cpu_rdata_3), .cpu_halt(cpu_halt_3),
    .dma_req(dma_req_3), .dma_addr(dma_addr_3), .dma_gnt(dma_gnt_3), .dma_ack(dma_ack_3),
    .dma_rdata(dma_rdata_3), .phi1(phi1_3), .phi2(phi2_3), .mem_addr(mem_addr_3),
    .mem_data_in(mem_data_in_3), .mem_read_e(mem_read_e_3), .mem_data_out(mem_data_out_3)
  );

  // Power-up memory contents; 0x1234 holds 0xA5.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Test memories: register on phi2 rise; bit 8 marks a written location.
  bit [8:0] mem_w  [65536];
  bit [8:0] mem3_w [65536];
  always @(posedge phi2) begin
    if (mem_read_e) mem_data_out <= mem_w[mem_addr][8] ? mem_w[mem_addr][7:0] : init_val(mem_addr);
    else            mem_w[mem_addr] <= {1'b1, mem_data_in};
  end
  always @(posedge phi2_3) begin
    if (mem_read_e_3) mem_data_out_3 <= mem3_w[mem_addr_3][8] ? mem3_w[mem_addr_3][7:0] : init_val(mem_addr_3);
    else              mem3_w[mem_addr_3] <= {1'b1, mem_data_in_3};
  end

  // Reference model state.
  logic [7:0]  ref_mem [65536];
  logic [7:0]  exp_cpu_rd;
  logic [15:0] pool [8];

  // Runs one bus cycle on the PHASE_LEN=1 instance and reports what it observed.
  task automatic txn(input bit dma, input bit we, input logic [15:0] a, input logic [7:0] wd,
                     output int lat, output logic [7:0] rd, output int p1_first, output int p2_first,
                     output int p1_cnt, output int p2_cnt, output bit bus_ok, output bit pulse_ok);
    int w;
    lat = -1; rd = 8'h00; p1_first = -1; p2_first = -1; p1_cnt = 0; p2_cnt = 0;
    bus_ok = 1'b1; pulse_ok = 1'b0;
    @(negedge clk);
    if (dma) begin dma_req = 1'b1; dma_addr = a; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    #1;
    w = 0;
    while (!(dma ? dma_gnt : cpu_gnt) && w < 200) begin @(negedge clk); #1; w++; end
    if (w >= 200) begin cpu_req = 1'b0; dma_req = 1'b0; return; end
    @(posedge clk);
    #1;
    cpu_req = 1'b0; dma_req = 1'b0;
    cpu_addr = 16'($urandom); dma_addr = 16'($urandom);
    cpu_wdata = 8'($urandom); cpu_we = 1'($urandom_range(0, 1));
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (phi1) begin p1_cnt++; if (p1_first < 0) p1_first = n; end
      if (phi2) begin p2_cnt++; if (p2_first < 0) p2_first = n; end
      if (phi1 && phi2) bus_ok = 1'b0;
      if (mem_addr !== a) bus_ok = 1'b0;
      if (mem_read_e !== (dma ? 1'b1 : ~we)) bus_ok = 1'b0;
      if (!dma && mem_data_in !== wd) bus_ok = 1'b0;
      if (dma ? cpu_ack : dma_ack) bus_ok = 1'b0;
      if (dma ? dma_ack : cpu_ack) begin
        lat = n;
        rd = dma ? dma_rdata : cpu_rdata;
        break;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      pulse_ok = !(dma ? dma_ack : cpu_ack);
    end
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 16'($urandom);
      cpu_wdata = 8'($urandom); dma_req = 1'($urandom); dma_addr = 16'($urandom);
      #1;
      total++;
      if ({phi1, phi2, mem_addr, mem_data_in, mem_read_e, cpu_ack, dma_ack, cpu_rdata, dma_rdata, cpu_halt}
          !== {1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
        bad++;
        $display("FAIL reset_outputs: got %h/%h/%h/%h/%h/%h/%h/%h/%h/%h", phi1, phi2, mem_addr, mem_data_in,
                 mem_read_e, cpu_ack, dma_ack, cpu_rdata, dma_rdata, cpu_halt);
      end
      total++;
      if (dma_gnt !== dma_req || cpu_gnt !== (cpu_req & ~dma_req)) begin
        bad++;
        $display("FAIL reset_grants: got cpu_gnt=%b dma_gnt=%b want %b %b", cpu_gnt, dma_gnt,
                 cpu_req & ~dma_req, dma_req);
      end
    end
    total++;
    if ({phi1_3, phi2_3, mem_read_e_3, cpu_halt_3} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_outputs_p3: got %b want 0010", {phi1_3, phi2_3, mem_read_e_3, cpu_halt_3});
    end
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0; rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL reset_first_gnt: got %b want 1", cpu_gnt); end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_read;
    int lat, p1f, p2f, p1c, p2c; logic [7:0] rd; bit bok, pok;
    txn(1'b0, 1'b0, 16'h1234, 8'h00, lat, rd, p1f, p2f, p1c, p2c, bok, pok);
    total++; if (lat !== 4) begin bad++; $display("FAIL cpu_read_latency: got %0d want 4", lat); end
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL cpu_read_data: got %h want a5", rd); end
    total++; if (p1f !== 1 || p1c !== 1) begin bad++; $display("FAIL cpu_read_phi1: got first=%0d len=%0d want 1 1", p1f, p1c); end
    total++; if (p2f !== 3 || p2c !== 1) begin bad++; $display("FAIL cpu_read_phi2: got first=%0d len=%0d want 3 1", p2f, p2c); end
    total++; if (!bok) begin bad++; $display("FAIL cpu_read_bus: got unstable/overlap want stable"); end
    total++; if (!pok) begin bad++; $display("FAIL cpu_read_ack_pulse: got ack held want 1-cycle pulse"); end
    exp_cpu_rd = 8'hA5;
  endtask

  task automatic test_write_read;
    int lat, p1f, p2f, p1c, p2c; logic [7:0] rd; bit bok, pok;
    txn(1'b0, 1'b1, 16'h0200, 8'h3C, lat, rd, p1f, p2f, p1c, p2c, bok, pok);
    ref_mem[16'h0200] = 8'h3C;
    total++; if (lat !== 4) begin bad++; $display("FAIL write_latency: got %0d want 4", lat); end
    total++; if (rd !== exp_cpu_rd) begin bad++; $display("FAIL write_rdata_held: got %h want %h", rd, exp_cpu_rd); end
    total++; if (!bok) begin bad++; $display("FAIL write_bus: got read_e/addr/data wrong want write held"); end
    total++; if (!pok) begin bad++; $display("FAIL write_ack_pulse: got ack held want pulse"); end
    txn(1'b0, 1'b0, 16'h0200, 8'h00, lat, rd, p1f, p2f, p1c, p2c, bok, pok);
    total++; if (rd !== 8'h3C || lat !== 4) begin bad++; $display("FAIL read_after_write: got %h lat=%0d want 3c lat=4", rd, lat); end
    exp_cpu_rd = 8'h3C;
  endtask

  task automatic test_dma_priority;
    int w, lat; bit ok;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300; dma_req = 1'b1; dma_addr = 16'h4000;
    #1;
    total++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      bad++; $display("FAIL prio_grants: got dma=%b cpu=%b want 1 0", dma_gnt, cpu_gnt);
    end
    @(posedge clk);
    #1;
    dma_req = 1'b0;
    @(negedge clk);
    total++; if (cpu_halt !== 1'b1) begin bad++; $display("FAIL prio_halt_rise: got %b want 1", cpu_halt); end
    ok = 1'b1; w = 0;
    while (!dma_ack && w < 40) begin if (cpu_gnt) ok = 1'b0; @(negedge clk); w++; end
    total++; if (w >= 40) begin bad++; $display("FAIL prio_dma_ack: got timeout want ack"); end
    total++; if (dma_rdata !== ref_mem[16'h4000]) begin bad++; $display("FAIL prio_dma_data: got %h want %h", dma_rdata, ref_mem[16'h4000]); end
    total++; if (!ok) begin bad++; $display("FAIL prio_cpu_starved: got cpu_gnt during dma want 0"); end
    w = 0;
    @(negedge clk);
    while (!cpu_gnt && w < 20) begin @(negedge clk); w++; end
    total++;
    if (w !== 1 || cpu_halt !== 1'b0) begin
      bad++; $display("FAIL prio_halt_fall: got wait=%0d halt=%b want 1 0", w, cpu_halt);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cpu_ack) begin lat = n; break; end
    end
    total++;
    if (lat !== 4 || cpu_rdata !== ref_mem[16'h0300]) begin
      bad++; $display("FAIL prio_cpu_after: got lat=%0d data=%h want 4 %h", lat, cpu_rdata, ref_mem[16'h0300]);
    end
    exp_cpu_rd = ref_mem[16'h0300];
  endtask

  task automatic test_random;
    int lat, p1f, p2f, p1c, p2c; logic [7:0] rd, exp_rd, wd; bit bok, pok, dma, we;
    logic [15:0] a;
    pool = '{16'h0200, 16'h0300, 16'h4000, 16'h1234, 16'hFFFF, 16'h0000,
             16'($urandom), 16'($urandom)};
    for (int i = 0; i < 40; i++) begin
      dma = 1'($urandom_range(0, 1));
      we  = dma ? 1'b0 : 1'($urandom_range(0, 1));
      a   = pool[$urandom_range(0, 7)];
      wd  = 8'($urandom);
      txn(dma, we, a, wd, lat, rd, p1f, p2f, p1c, p2c, bok, pok);
      exp_rd = (!dma && we) ? exp_cpu_rd : ref_mem[a];
      if (!dma && we) ref_mem[a] = wd;
      if (!dma && !we) exp_cpu_rd = exp_rd;
      total++; if (lat !== 4) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 4", i, lat); end
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h (dma=%b we=%b a=%h)", i, rd, exp_rd, dma, we, a); end
      total++; if (!bok) begin bad++; $display("FAIL rand_bus[%0d]: got bad bus want stable", i); end
      total++; if (!pok) begin bad++; $display("FAIL rand_pulse[%0d]: got ack held want pulse", i); end
    end
  endtask

  task automatic test_phase3;
    bit s1 [40]; bit s2 [40]; bit sa [40];
    int acc_idx[$]; logic [7:0] rds[$];
    int m1, m2, ma, off; bit e1, e2, ea;
    @(negedge clk);
    cpu_req_3 = 1'b1; cpu_we_3 = 1'b0; cpu_addr_3 = 16'h4000;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      s1[k] = phi1_3; s2[k] = phi2_3; sa[k] = cpu_ack_3;
      if (cpu_ack_3) rds.push_back(cpu_rdata_3);
      if (cpu_req_3 && cpu_gnt_3) acc_idx.push_back(k);
      @(posedge clk);
      #1;
      if (acc_idx.size() >= 2) cpu_req_3 = 1'b0;
    end
    m1 = 0; m2 = 0; ma = 0;
    for (int k = 0; k < 40; k++) begin
      e1 = 1'b0; e2 = 1'b0; ea = 1'b0;
      foreach (acc_idx[j]) begin
        off = k - (acc_idx[j] + 1);
        if (off >= 1 && off <= P3) e1 = 1'b1;
        if (off >= P3 + 2 && off <= 2 * P3 + 1) e2 = 1'b1;
        if (off == 2 * P3 + 2) ea = 1'b1;
      end
      if (s1[k] != e1) m1++;
      if (s2[k] != e2) m2++;
      if (sa[k] != ea) ma++;
    end
    total++;
    if (acc_idx.size() != 2) begin
      bad++; $display("FAIL p3_accepts: got %0d want 2", acc_idx.size());
    end else begin
      total++;
      if (acc_idx[1] - acc_idx[0] != 4 + 2 * P3) begin
        bad++; $display("FAIL p3_period: got %0d want %0d", acc_idx[1] - acc_idx[0], 4 + 2 * P3);
      end
    end
    total++; if (m1 != 0) begin bad++; $display("FAIL p3_phi1: got %0d wrong cycles want 0", m1); end
    total++; if (m2 != 0) begin bad++; $display("FAIL p3_phi2: got %0d wrong cycles want 0", m2); end
    total++; if (ma != 0) begin bad++; $display("FAIL p3_ack: got %0d wrong cycles want 0", ma); end
    total++;
    if (rds.size() != 2 || rds[0] !== init_val(16'h4000) || rds[1] !== init_val(16'h4000)) begin
      bad++; $display("FAIL p3_data: got %0d acks want 2 of %h", rds.size(), init_val(16'h4000));
    end
  endtask

  task automatic test_reset_abort;
    int w, lat, p1f, p2f, p1c, p2c; logic [7:0] rd; bit bok, pok, ok;
    logic [15:0] a;
    a = 16'h7777;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = ref_mem[a];
    #1;
    w = 0;
    while (!cpu_gnt && w < 50) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    w = 0;
    @(negedge clk);
    while (!phi2 && w < 20) begin @(negedge clk); w++; end
    total++; if (w >= 20) begin bad++; $display("FAIL abort_reach_ph2: got timeout want phi2"); end
    #2;
    rst_b = 1'b0;
    #1;
    total++;
    if ({phi1, phi2, mem_read_e, cpu_ack} !== 4'b0010) begin
      bad++; $display("FAIL abort_async: got %b want 0010", {phi1, phi2, mem_read_e, cpu_ack});
    end
    ok = 1'b1;
    repeat (3) begin @(negedge clk); if (cpu_ack || phi1 || phi2) ok = 1'b0; end
    rst_b = 1'b1;
    repeat (6) begin @(negedge clk); if (cpu_ack || phi1 || phi2) ok = 1'b0; end
    total++; if (!ok) begin bad++; $display("FAIL abort_no_ack: got ack/strobe want quiet"); end
    total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL abort_rdata_reset: got %h want 00", cpu_rdata); end
    exp_cpu_rd = 8'h00;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    #1;
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL abort_regrant: got %b want 1", cpu_gnt); end
    cpu_req = 1'b0;
    txn(1'b0, 1'b0, 16'h0200, 8'h00, lat, rd, p1f, p2f, p1c, p2c, bok, pok);
    total++;
    if (lat !== 4 || rd !== ref_mem[16'h0200]) begin
      bad++; $display("FAIL abort_next_read: got lat=%0d data=%h want 4 %h", lat, rd, ref_mem[16'h0200]);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    dma_req = 1'b0; dma_addr = 16'h0;
    cpu_req_3 = 1'b0; cpu_we_3 = 1'b0; cpu_addr_3 = 16'h0; cpu_wdata_3 = 8'h0;
    dma_req_3 = 1'b0; dma_addr_3 = 16'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    exp_cpu_rd = 8'h00;
    test_reset;
    test_cpu_read;
    test_write_read;
    test_dma_priority;
    test_random;
    test_phase3;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
